// File: rtl/shreg_tx.sv
// shreg_tx: parallel-to-serial transmitter.
// Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one
// bit at a time on sout, holding each bit for DIV enabled clock cycles.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   en         - shift enable; freezes divider and bit counter when low
//   din        - word to transmit, sampled on handshake
//   din_valid  - producer has a word on din
//   din_ready  - block can accept a word (combinational)
//   sout       - registered serial data
//   sout_valid - high while a frame bit is on sout
//   busy       - high while shifting
//   done       - one-cycle pulse after the last bit of a frame
//   status     - high when idle
module shreg_tx #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done,
    output logic             status
);

    localparam int BW = $clog2(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [BW-1:0]    bitcnt, bitcnt_n;
    logic [DW-1:0]    divcnt, divcnt_n;
    logic             sout_n, sout_valid_n, busy_n, done_n;

    // Shifted register and the bit that becomes visible after the shift;
    // sout is registered, so the next bit is taken from the pre-shift value.
    logic [WIDTH-1:0] shreg_shifted;
    logic             next_bit;
    logic             first_bit;

    always_comb begin
        if (MSB_FIRST != 0) begin
            shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
            next_bit      = shreg[WIDTH-2];
            first_bit     = din[WIDTH-1];
        end else begin
            shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
            next_bit      = shreg[1];
            first_bit     = din[0];
        end
    end

    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        bitcnt_n     = bitcnt;
        divcnt_n     = divcnt;
        sout_n       = sout;
        sout_valid_n = sout_valid;
        busy_n       = busy;
        done_n       = 1'b0;
        case (state)
            IDLE: begin
                if (din_valid) begin
                    state_n      = SHIFT;
                    shreg_n      = din;
                    bitcnt_n     = '0;
                    divcnt_n     = '0;
                    sout_n       = first_bit;
                    sout_valid_n = 1'b1;
                    busy_n       = 1'b1;
                end
            end
            SHIFT: begin
                if (en) begin
                    if (divcnt == DIV_LAST) begin
                        divcnt_n = '0;
                        if (bitcnt == BIT_LAST) begin
                            state_n      = IDLE;
                            bitcnt_n     = '0;
                            shreg_n      = shreg_shifted;
                            sout_n       = 1'b0;
                            sout_valid_n = 1'b0;
                            busy_n       = 1'b0;
                            done_n       = 1'b1;
                        end else begin
                            shreg_n  = shreg_shifted;
                            bitcnt_n = bitcnt + 1'b1;
                            sout_n   = next_bit;
                        end
                    end else begin
                        divcnt_n = divcnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bitcnt     <= '0;
            divcnt     <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bitcnt     <= bitcnt_n;
            divcnt     <= divcnt_n;
            sout       <= sout_n;
            sout_valid <= sout_valid_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    assign status    = (state == IDLE);
    assign din_ready = (state == IDLE) && !rst;

endmodule

// File: tb/tb_shreg_tx.sv
// Testbench for shreg_tx: three instances (DIV=2 MSB first, DIV=2 LSB first,
// DIV=1 MSB first) checked every cycle against a frame-level model, plus
// directed frames with hand-computed expected bit sequences.
module tb_shreg_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       en   [3];
    logic [7:0] din  [3];
    logic       dv   [3];
    logic       rdy  [3];
    logic       so   [3];
    logic       sv   [3];
    logic       bz   [3];
    logic       dn   [3];
    logic       st   [3];

    int checks = 0;
    int errors = 0;

    int DIVS [3] = '{2, 2, 1};
    bit MSBF [3] = '{1'b1, 1'b0, 1'b1};
    bit pat  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    shreg_tx #(.WIDTH(8), .DIV(2), .MSB_FIRST(1)) u0 (
        .clk(clk), .rst(rst), .en(en[0]), .din(din[0]), .din_valid(dv[0]),
        .din_ready(rdy[0]), .sout(so[0]), .sout_valid(sv[0]), .busy(bz[0]),
        .done(dn[0]), .status(st[0]));
    shreg_tx #(.WIDTH(8), .DIV(2), .MSB_FIRST(0)) u1 (
        .clk(clk), .rst(rst), .en(en[1]), .din(din[1]), .din_valid(dv[1]),
        .din_ready(rdy[1]), .sout(so[1]), .sout_valid(sv[1]), .busy(bz[1]),
        .done(dn[1]), .status(st[1]));
    shreg_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(1)) u2 (
        .clk(clk), .rst(rst), .en(en[2]), .din(din[2]), .din_valid(dv[2]),
        .din_ready(rdy[2]), .sout(so[2]), .sout_valid(sv[2]), .busy(bz[2]),
        .done(dn[2]), .status(st[2]));

    // Frame-level model: a frame is a captured word plus the number of
    // enabled cycles spent on it; the current bit is that count / DIV.
    logic       act   [3];
    logic       mdone [3];
    int         ecnt  [3];
    logic [7:0] word  [3];
    bit         minit = 1'b0;

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                act[d]   <= 1'b0;
                mdone[d] <= 1'b0;
                ecnt[d]  <= 0;
            end else begin
                mdone[d] <= 1'b0;
                if (!act[d]) begin
                    if (dv[d]) begin
                        act[d]  <= 1'b1;
                        word[d] <= din[d];
                        ecnt[d] <= 0;
                    end
                end else if (en[d]) begin
                    ecnt[d] <= ecnt[d] + 1;
                    if (ecnt[d] + 1 == 8 * DIVS[d]) begin
                        act[d]   <= 1'b0;
                        mdone[d] <= 1'b1;
                    end
                end
            end
        end
        if (rst) minit <= 1'b1;
    end

    task automatic check(input string nm, input int d, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s dut%0d: got %b expected %b at %0t", nm, d, a, e, $time);
        end
    endtask

    task automatic checkv(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (minit) begin
            for (int d = 0; d < 3; d++) begin
                logic eso;
                int   idx;
                eso = 1'b0;
                if (act[d]) begin
                    idx = ecnt[d] / DIVS[d];
                    eso = MSBF[d] ? word[d][7-idx] : word[d][idx];
                end
                check("sout", d, so[d], eso);
                check("sout_valid", d, sv[d], act[d]);
                check("busy", d, bz[d], act[d]);
                check("done", d, dn[d], mdone[d]);
                check("status", d, st[d], !act[d]);
                check("din_ready", d, rdy[d], !act[d] && !rst);
            end
        end
    end

    task automatic wait_idle(input int d);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (st[d] && rdy[d]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", d, 1'b0, 1'b1);
    endtask

    // Handshake a word, then observe ncyc cycles after the handshake edge.
    // bits collects sout on cycles with sout_valid and en both high.
    task automatic frame(input int d, input logic [7:0] w, input bit hold,
                         input logic [7:0] nxt, input bit tog, input int ncyc,
                         output logic [63:0] bits, output int nvalid,
                         output int donecyc, output bit rdy_seen);
        wait_idle(d);
        @(posedge clk); #1;
        din[d] = w; dv[d] = 1'b1; en[d] = 1'b1;
        @(posedge clk); #1;
        if (hold) din[d] = nxt;
        else dv[d] = 1'b0;
        en[d] = tog ? pat[0] : 1'b1;
        bits = '0; nvalid = 0; donecyc = -1; rdy_seen = 1'b0;
        for (int j = 1; j <= ncyc; j++) begin
            @(negedge clk);
            if (sv[d]) nvalid++;
            if (dn[d] && donecyc < 0) donecyc = j;
            if (sv[d] && rdy[d]) rdy_seen = 1'b1;
            if (sv[d] && en[d]) bits = {bits[62:0], so[d]};
            @(posedge clk); #1;
            en[d] = tog ? pat[j % 4] : 1'b1;
        end
        dv[d] = 1'b0;
        en[d] = 1'b1;
    endtask

    initial begin
        logic [63:0] bits;
        int          nvalid, donecyc;
        bit          rseen;

        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            en[d] = 1'b1; din[d] = '0; dv[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ready", 0, rdy[0], 1'b1);
        check("reset_sout", 0, so[0], 1'b0);
        check("reset_done", 0, dn[0], 1'b0);

        // A5, DIV=2, MSB first
        frame(0, 8'hA5, 1'b0, 8'h00, 1'b0, 17, bits, nvalid, donecyc, rseen);
        checkv("a5_msb_bits", bits[15:0], 64'hCC33);
        checkv("a5_msb_nvalid", 64'(nvalid), 64'd16);
        checkv("a5_msb_done_cycle", 64'(donecyc), 64'd17);

        // A5 then 01, DIV=2, LSB first
        frame(1, 8'hA5, 1'b0, 8'h00, 1'b0, 17, bits, nvalid, donecyc, rseen);
        checkv("a5_lsb_bits", bits[15:0], 64'hCC33);
        frame(1, 8'h01, 1'b0, 8'h00, 1'b0, 17, bits, nvalid, donecyc, rseen);
        checkv("01_lsb_bits", bits[15:0], 64'hC000);
        checkv("01_lsb_done_cycle", 64'(donecyc), 64'd17);

        // F0 with en pattern 1,0,0,1
        frame(0, 8'hF0, 1'b0, 8'h00, 1'b1, 34, bits, nvalid, donecyc, rseen);
        checkv("f0_en_bits", bits[15:0], 64'hFF00);
        checkv("f0_en_nvalid", 64'(nvalid), 64'd32);
        checkv("f0_en_done_cycle", 64'(donecyc), 64'd33);

        // 3C held on din during an A5 frame
        frame(0, 8'hA5, 1'b1, 8'h3C, 1'b0, 18, bits, nvalid, donecyc, rseen);
        checkv("busy_in_bits", bits[16:0], 64'h19866);
        checkv("busy_in_nvalid", 64'(nvalid), 64'd17);
        checkv("busy_in_done_cycle", 64'(donecyc), 64'd17);
        check("busy_in_ready_low", 0, rseen, 1'b0);

        // Back-to-back 81 / 7E with DIV=1
        frame(2, 8'h81, 1'b1, 8'h7E, 1'b0, 17, bits, nvalid, donecyc, rseen);
        checkv("b2b_bits", bits[15:0], 64'h817E);
        checkv("b2b_nvalid", 64'(nvalid), 64'd16);
        checkv("b2b_done_cycle", 64'(donecyc), 64'd9);

        // Reset during the 5th bit of an A5 frame
        wait_idle(0);
        @(posedge clk); #1;
        din[0] = 8'hA5; dv[0] = 1'b1;
        @(posedge clk); #1;
        dv[0] = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_pre_valid", 0, sv[0], 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_sout", 0, so[0], 1'b0);
        check("rst_valid", 0, sv[0], 1'b0);
        check("rst_busy", 0, bz[0], 1'b0);
        check("rst_done", 0, dn[0], 1'b0);
        check("rst_ready_low", 0, rdy[0], 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", 0, rdy[0], 1'b1);
        repeat (4) @(negedge clk);

        // Randomized traffic on all three instances
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 199) == 0);
            for (int d = 0; d < 3; d++) begin
                en[d]  = ($urandom_range(0, 3) != 0);
                dv[d]  = ($urandom_range(0, 2) == 0);
                din[d] = 8'($urandom);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) dv[d] = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
